// File: rtl/riscv_pkg.sv
// Shared RV32 core types used across the front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0: shown to decode whenever the fetch buffer is empty.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One prefetch buffer entry: the instruction and the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with show-ahead head.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: none internal; caller never pushes when full nor pops when empty.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push/push_data  write one entry
//   pop             retire the head entry
//   flush           drop all entries; wins over push and pop in the same cycle
//   head            current head entry (undefined when count == 0)
//   count           number of valid entries, 0..DEPTH
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: count gates everything read out of it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/fetch_unit.sv
// RISC-V instruction fetch: PC owner, imem requester, prefetch buffer to decode.
// Latency: response beat in cycle N appears at valid_d in N+1; redirect empties outputs in N+1.
// Backpressure: credit-limited requests (outstanding + buffered <= FIFO_DEPTH); stall_d holds head.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req_valid/ready     request channel, imem_req_addr = current fetch PC (word aligned)
//   imem_rsp_valid/data      in-order response beats
//   redirect_valid/pc        taken branch/jump from execute; flushes and refetches
//   stall_d                  decode cannot accept the head this cycle
//   valid_d/instr_d/pc_d/pc_plus4_d   head entry (NOP/0/0 when empty)
// Optional: define FETCH_PERF_EN to add perf_fetched / perf_bubbles counters.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  stall_d,
  output logic                  valid_d,
  output logic [DATA_WIDTH-1:0] instr_d,
  output logic [ADDR_WIDTH-1:0] pc_d,
  output logic [ADDR_WIDTH-1:0] pc_plus4_d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_bubbles
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] rsp_pc;
  logic [ADDR_WIDTH-1:0] redirect_pc_al;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         discard;
  logic [CW-1:0]         count;
  logic [CW:0]           credit_used;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  rsp_ok;
  fetch_entry_t          push_entry;
  fetch_entry_t          head_entry;

  assign redirect_pc_al = redirect_pc & ~ADDR_WIDTH'(3);

  assign valid_d = ~rst & (count != '0);
  assign pop     = valid_d & ~stall_d;

  // Every in-flight request owns a buffer slot, so the buffer can never overflow.
  // A same-cycle pop frees a slot early, which keeps L=1 fetch at one per cycle.
  assign credit_used    = {1'b0, outstanding} + {1'b0, count} - (CW+1)'(pop);
  assign imem_req_valid = ~rst & ~redirect_valid & (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign issue          = imem_req_valid & imem_req_ready;

  // A beat with nothing outstanding is a protocol error; it is ignored.
  assign rsp_ok = imem_rsp_valid & (outstanding != '0);
  // Beats from before a redirect are dropped while discard is non-zero.
  assign push   = rsp_ok & (discard == '0) & ~redirect_valid;

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = XLEN'(rsp_pc);
    push_entry.instr = XLEN'(imem_rsp_data);
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop & ~redirect_valid),
    .flush     (redirect_valid),
    .head      (head_entry),
    .count     (count)
  );

  always_comb begin
    instr_d    = DATA_WIDTH'(NOP_INSTR);
    pc_d       = '0;
    pc_plus4_d = '0;
    if (valid_d) begin
      instr_d    = DATA_WIDTH'(head_entry.instr);
      pc_d       = ADDR_WIDTH'(head_entry.pc);
      pc_plus4_d = ADDR_WIDTH'(head_entry.pc) + ADDR_WIDTH'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      // A redirect cycle never issues, so outstanding only tracks the bus.
      case ({issue, rsp_ok})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      if (redirect_valid) begin
        pc      <= redirect_pc_al;
        rsp_pc  <= redirect_pc_al;
        // Beats still on the bus after this cycle all belong to the old path.
        discard <= outstanding - CW'(rsp_ok);
      end else begin
        if (issue) pc <= pc + ADDR_WIDTH'(4);
        if (push)  rsp_pc <= rsp_pc + ADDR_WIDTH'(4);
        if (rsp_ok && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (pop)                 perf_fetched <= perf_fetched + 32'd1;
      if (!valid_d && !stall_d) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

  a_rsp_without_req: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (outstanding == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency in-order memory model.
// Latency: memory answers an accepted request L cycles later (L set per phase).
// Backpressure: imem_req_ready is either held high or randomised per cycle.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        stall_d        = 1'b0;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;

  fetch_unit #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_d        (stall_d),
    .valid_d        (valid_d),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pc_plus4_d     (pc_plus4_d)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // ---------------- memory model ----------------
  int          lat        = 1;
  logic        rand_ready = 1'b0;
  int          cyc        = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic        acc_q = 1'b0;
  logic        rsp_q = 1'b0;
  logic [31:0] acc_addr_q = '0;

  always @(negedge clk) begin
    acc_q      = imem_req_valid & imem_req_ready;
    acc_addr_q = imem_req_addr;
    rsp_q      = imem_rsp_valid;
  end

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (rsp_q && pend_addr.size() > 0) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (acc_q) begin
      pend_addr.push_back(acc_addr_q);
      pend_due.push_back(cyc - 1 + lat);
    end
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- in-order consumption and request-address model ----------------
  logic        sb_en        = 1'b0;
  logic [31:0] exp_pc       = RST_PC;
  logic [31:0] exp_req_addr = RST_PC;
  logic        hold_pending = 1'b0;
  int          pops         = 0;

  always @(negedge clk) begin
    if (sb_en && !rst) begin
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~32'h3;
      end else if (valid_d && !stall_d) begin
        check("pop_pc", pc_d, exp_pc);
        check("pop_instr", instr_d, mem_word(exp_pc));
        check("pop_pc4", pc_plus4_d, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end

      if (hold_pending && !redirect_valid) check("req_hold", 32'(imem_req_valid), 32'd1);
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_addr);
      if (redirect_valid) exp_req_addr = redirect_pc & ~32'h3;
      else if (imem_req_valid && imem_req_ready) exp_req_addr = exp_req_addr + 32'd4;
      hold_pending = imem_req_valid && !imem_req_ready;
    end
  end

  // ---------------- directed sequence ----------------
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = valid_d;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    logic found;
    int   bp_start;

    repeat (3) tick;
    @(negedge clk);
    check("rst_valid_d", 32'(valid_d), 32'd0);
    check("rst_instr", instr_d, 32'h0000_0013);
    check("rst_pc_d", pc_d, 32'd0);
    check("rst_pc4", pc_plus4_d, 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);

    // Release reset: first request at RESET_PC in this very cycle.
    tick;
    rst   = 1'b0;
    sb_en = 1'b1;
    @(negedge clk);
    check("r0_req_valid", 32'(imem_req_valid), 32'd1);
    check("r0_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    check("r0_valid_d", 32'(valid_d), 32'd0);
    tick;
    @(negedge clk);
    check("r1_wrap_addr", imem_req_addr, 32'h0000_0000);
    check("r1_valid_d", 32'(valid_d), 32'd0);
    tick;
    @(negedge clk);
    check("r2_valid_d", 32'(valid_d), 32'd1);
    check("r2_pc_d", pc_d, 32'hFFFF_FFFC);
    check("r2_pc4_wrap", pc_plus4_d, 32'h0000_0000);
    check("r2_instr", instr_d, mem_word(32'hFFFF_FFFC));
    for (int i = 0; i < 6; i++) begin
      tick;
      @(negedge clk);
      check("thru_valid_d", 32'(valid_d), 32'd1);
    end

    // Stall for 3 cycles: buffer fills, requests stop, head is held.
    tick;
    stall_d = 1'b1;
    @(negedge clk);
    check("stall0_pc_d", pc_d, exp_pc);
    for (int i = 0; i < 2; i++) begin
      tick;
      @(negedge clk);
      check("stall_req_valid", 32'(imem_req_valid), 32'd0);
      check("stall_pc_d", pc_d, exp_pc);
      check("stall_valid_d", 32'(valid_d), 32'd1);
    end
    tick;
    stall_d = 1'b0;
    repeat (4) tick;

    // Redirect with two beats in flight and none returning this cycle.
    lat   = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick;
      found = (pend_addr.size() == 2) && !imem_rsp_valid;
    end
    check("rd1_setup", 32'(found), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    @(negedge clk);
    check("rd1_withdraw", 32'(imem_req_valid), 32'd0);
    tick;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    @(negedge clk);
    check("rd1_valid_d_off", 32'(valid_d), 32'd0);
    check("rd1_no_credit", 32'(imem_req_valid), 32'd0);
    wait_valid("rd1_wait_valid");
    check("rd1_pc_d", pc_d, 32'h0000_0100);
    check("rd1_instr", instr_d, mem_word(32'h0000_0100));

    // Misaligned redirect while a stale beat returns in the same cycle.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick;
      found = (pend_addr.size() == 2) && imem_rsp_valid;
    end
    check("rd2_setup", 32'(found), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    tick;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    @(negedge clk);
    check("rd2_req_valid", 32'(imem_req_valid), 32'd1);
    check("rd2_req_addr", imem_req_addr, 32'h0000_0200);
    check("rd2_valid_d_off", 32'(valid_d), 32'd0);
    wait_valid("rd2_wait_valid");
    check("rd2_pc_d", pc_d, 32'h0000_0200);
    check("rd2_instr", instr_d, mem_word(32'h0000_0200));

    // Random request backpressure and occasional decode stalls.
    lat        = 2;
    rand_ready = 1'b1;
    bp_start   = pops;
    for (int i = 0; i < 80; i++) begin
      tick;
      stall_d = ($urandom_range(0, 3) == 0);
    end
    tick;
    stall_d    = 1'b0;
    rand_ready = 1'b0;
    repeat (10) tick;
    check("bp_progress", 32'(pops - bp_start >= 10), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core: owns the PC, issues word requests to instruction memory over a valid/ready request channel, and buffers in-order responses in a small prefetch FIFO. It presents `{instr, pc, pc+4}` to the decode stage, which includes the immediate sign-extension unit. Branch/jump redirects flush the buffer and discard stale in-flight responses. Decode stalls hold the head entry.

## Interface
- `DATA_WIDTH`, 32: instruction width.
- `ADDR_WIDTH`, 32: PC width.
- `RESET_PC`, 32'h0000_0000: first fetch address.
- `FIFO_DEPTH`, 2: prefetch entries; also the maximum outstanding requests. Power of two, ≥2.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high. One clock; `rst` is sampled only on the rising edge of `clk`.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  ADDR_WIDTH  word address (bits [1:0] = 0).
- `imem_rsp_valid`  in  1  response beat, in request order.
- `imem_rsp_data`  in  DATA_WIDTH  instruction word.
- `redirect_valid`  in  1  taken branch/jump from execute.
- `redirect_pc`  in  ADDR_WIDTH  new fetch address.
- `stall_d`  in  1  decode cannot accept this cycle (hazard unit).
- `valid_d`  out  1  head entry valid.
- `instr_d`  out  DATA_WIDTH  instruction to decode.
- `pc_d`  out  ADDR_WIDTH  PC of `instr_d`.
- `pc_plus4_d`  out  ADDR_WIDTH  `pc_d + 4`.

## Operation
- **Reset** sets `pc` to `RESET_PC`, empties the FIFO, and clears `outstanding` and `discard`.
  - Outputs during and after reset: `valid_d`=0, `instr_d`=32'h0000_0013 (NOP), `pc_d`=0, `pc_plus4_d`=0, `imem_req_valid`=0.
- **Credit**:
  - `pop = valid_d & ~stall_d`.
  - `imem_req_valid = ~rst & ~redirect_valid & (outstanding + count - pop < FIFO_DEPTH)`.
  - `imem_req_addr = pc`.
- **Issue**: when `imem_req_valid & imem_req_ready`, `pc <= pc + 4` (wraps modulo 2^ADDR_WIDTH) and `outstanding++`.
- **Request hold**: `imem_req_valid` and `imem_req_addr` stay stable until accepted. The only exception is a redirect, which withdraws the request.
- **Response**:
  - Each `imem_rsp_valid` decrements `outstanding`.
  - If `discard > 0`, the beat is dropped and `discard--`.
  - Otherwise `{pc_of_req, data}` is pushed into the FIFO. The PC is tracked by a response-PC register that advances by 4 per accepted beat.
- **Head**: when the FIFO is non-empty, the outputs show the head entry and `valid_d`=1. When empty, the outputs show NOP/0/0 with `valid_d`=0.
- **Redirect** (priority over all other events in the same cycle):
  - `pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}`; the response-PC register is loaded with the same value.
  - FIFO cleared; any pop or push in that cycle is void.
  - `discard <= outstanding - imem_rsp_valid`, i.e. the beats still in flight after this cycle.
- **Simultaneous events**:
  - Push and pop in the same cycle on a full FIFO are legal.
  - Overflow cannot occur because of the credit rule.
  - Redirect coinciding with `stall_d` still flushes.
- **Illegal**: `imem_rsp_valid` while `outstanding`=0. An assertion fires; the beat is ignored.

## Timing
- The first request is issued in the first cycle after `rst` falls, at `RESET_PC`.
- Memory latency L is variable. A response in cycle N makes `valid_d`=1 in cycle N+1.
- Redirect in cycle N:
  - `valid_d`=0 in N+1.
  - Request at the new PC is issued in N+1 if a credit is free. Stale in-flight beats hold credits until they return.
- With `FIFO_DEPTH`=2 and L=1, sustained throughput is 1 instruction/cycle.
- `stall_d` freezes all `_d` outputs in the next cycle.

## Configuration
- `FETCH_PERF_EN` defined: adds output ports `perf_fetched` and `perf_bubbles` (each 32 bits).
  - Both reset to 0.
  - `perf_fetched` increments on each pop.
  - `perf_bubbles` increments each cycle with `valid_d`=0 and `~stall_d`.
  - Both counters wrap.
- `FETCH_PERF_EN` undefined: the ports and counters are absent; function is otherwise identical.

## Structure
- Shared package `riscv_pkg`:
  - `NOP_INSTR` (32'h0000_0013).
  - `fetch_entry_t` struct `{pc, instr}`.
- Sub-module `fetch_fifo`: synchronous FIFO with show-ahead head, `push`, `pop`, `flush`, and `count`.
- The credit, discard and PC logic live in `fetch_unit`.

## Test plan
- **Reset, steady fetch**: release `rst`, memory with ready=1 and L=1 -> requests at 0x0, 0x4, 0x8. `valid_d` rises on cycle 2 after reset release, then instructions are consumed 1 per cycle.
- **Stall**: `stall_d`=1 for 3 cycles with FIFO full -> `imem_req_valid`=0 and `pc_d` held. Fetch resumes on release with no lost or duplicated instruction.
- **Redirect with 2 in flight**: L=3, redirect to 0x100 -> both stale beats dropped. The next valid `pc_d`=0x100 with the matching data.
- **Misaligned redirect plus same-cycle response**: redirect to 0x203 while `imem_rsp_valid`=1 -> fetch at 0x200, and `discard` equals outstanding-1.
- **Backpressure**: `imem_req_ready` toggles randomly -> address stays stable while unaccepted and the instruction order is preserved.
- **PC wrap**: `RESET_PC`=32'hFFFF_FFFC -> second fetch at 0x0, and `pc_plus4_d`=0x0 for the first instruction.
